// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU/UART operand sequencer.
package alu_seq_pkg;

    localparam int unsigned N_BITS_DEF = 8;
    localparam int unsigned N_OPS_DEF  = 6;

    typedef enum logic [2:0] {
        S_A       = 3'd0,
        S_B       = 3'd1,
        S_OP      = 3'd2,
        S_EXEC    = 3'd3,
        S_CAPTURE = 3'd4,
        S_TX_WAIT = 3'd5
    } seq_state_e;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    // States in which the sequencer is waiting for an operand/opcode byte after the first.
    function automatic logic awaits_operand(input seq_state_e s);
        return (s == S_B) || (s == S_OP);
    endfunction

endpackage

// File: rtl/seq_timeout_timer.sv
// Inter-byte timeout counter: counts while enabled, pulses expire_o on the last count.
module seq_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, opcode bytes from the UART, drives the registered ALU and sends the result back.
// Optional inter-byte timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned N_BITS         = N_BITS_DEF,
    parameter int unsigned N_OPS          = N_OPS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_BITS-1:0] rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [N_BITS-1:0] alu_result,
    output logic [N_BITS-1:0] data_a,
    output logic [N_BITS-1:0] data_b,
    output logic [N_OPS-1:0]  op,
    output logic [N_BITS-1:0] tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              rx_drop
);

    seq_state_e        state_q;
    logic [N_BITS-1:0] data_a_q;
    logic [N_BITS-1:0] data_b_q;
    logic [N_OPS-1:0]  op_q;
    logic [N_BITS-1:0] tx_data_q;
    logic              tx_start_q;
    logic              busy_q;
    logic              rx_drop_q;
    logic              timeout_c;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic timer_en_c;
    logic timer_clr_c;

    assign timer_en_c  = awaits_operand(state_q);
    // Leaving B/OP always goes through rx_done or expiry, so this covers every state change.
    assign timer_clr_c = rx_done || !timer_en_c;

    seq_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (timer_clr_c),
        .enable_i (timer_en_c),
        .expire_o (timeout_c)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            rx_drop_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            rx_drop_q  <= 1'b0;
            case (state_q)
                S_A: begin
                    if (rx_done) begin
                        data_a_q <= rx_data;
                        state_q  <= S_B;
                    end
                end
                S_B: begin
                    if (rx_done) begin
                        data_b_q <= rx_data;
                        state_q  <= S_OP;
                    end else if (timeout_c) begin
                        state_q <= S_A;
                    end
                end
                S_OP: begin
                    if (rx_done) begin
                        op_q    <= rx_data[N_OPS-1:0];
                        state_q <= S_EXEC;
                        busy_q  <= 1'b1;
                    end else if (timeout_c) begin
                        state_q <= S_A;
                    end
                end
                S_EXEC: begin
                    rx_drop_q <= rx_done;
                    state_q   <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rx_drop_q  <= rx_done;
                    tx_data_q  <= alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    rx_drop_q <= rx_done;
                    if (tx_done) begin
                        state_q <= S_A;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_A;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_a   = data_a_q;
    assign data_b   = data_b_q;
    assign op       = op_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer with a behavioural registered ALU.
module tb_alu_uart_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned NB = 8;
    localparam int unsigned NO = 6;
    localparam int unsigned TO = 16;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] rx_data = '0;
    logic          rx_done = 1'b0;
    logic          tx_done = 1'b0;
    logic [NB-1:0] alu_result = '0;
    logic [NB-1:0] data_a, data_b, tx_data;
    logic [NO-1:0] op;
    logic          tx_start, busy, rx_drop;

    alu_uart_sequencer #(
        .N_BITS (NB), .N_OPS (NO), .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_done    (tx_done),
        .alu_result (alu_result),
        .data_a     (data_a),
        .data_b     (data_b),
        .op         (op),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .rx_drop    (rx_drop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [NB-1:0] alu_f(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                            input logic [NO-1:0] o);
        case (o)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return NB'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            default: return '0;
        endcase
    endfunction

    always @(posedge clock) alu_result <= alu_f(data_a, data_b, op);

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [NB-1:0] data;
        int            cyc;
    } tx_exp_t;

    tx_exp_t tx_q[$];
    int      drop_q[$];

    // Monitor: every tx_start and rx_drop pulse must match a queued expectation.
    always @(negedge clock) begin
        tx_exp_t e;
        int      dc;
        if (tx_start) begin
            if (tx_q.size() == 0) check("unexpected_tx_start", 32'd1, 32'd0);
            else begin
                e = tx_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e.data));
                check("tx_start_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (rx_drop) begin
            if (drop_q.size() == 0) check("unexpected_rx_drop", 32'd1, 32'd0);
            else begin
                dc = drop_q.pop_front();
                check("rx_drop_cycle", 32'(cyc), 32'(dc));
            end
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [NB-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clock);
        rx_done = 1'b0;
    endtask

    task automatic send_op(input logic [NB-1:0] b, input logic [NB-1:0] exp);
        tx_q.push_back('{exp, cyc + 3});
        send_byte(b);
    endtask

    task automatic wait_tx_start();
        int n = 0;
        while (!tx_start && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (!tx_start) check("tx_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_tx();
        @(negedge clock);
        check("busy_in_tx_wait", 32'(busy), 32'd1);
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        check("busy_after_tx_done", 32'(busy), 32'd0);
    endtask

    task automatic run_txn(input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input logic [NB-1:0] o, input logic [NB-1:0] exp);
        send_byte(a);
        send_byte(b);
        send_op(o, exp);
        check("op", 32'(op), 32'(o[NO-1:0]));
        check("data_a", 32'(data_a), 32'(a));
        check("data_b", 32'(data_b), 32'(b));
        check("busy_exec", 32'(busy), 32'd1);
        wait_tx_start();
        end_tx();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_a"}, 32'(data_a), 32'd0);
        check({tag, "_data_b"}, 32'(data_b), 32'd0);
        check({tag, "_op"}, 32'(op), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_ctrl"}, {29'd0, tx_start, busy, rx_drop}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        check_all_zero("reset");

        run_txn(8'h05, 8'h03, 8'h20, 8'h08);
        run_txn(8'h03, 8'h05, 8'h22, 8'hFE);
        run_txn(8'hF0, 8'h0F, 8'h25, 8'hFF);

        // Byte arriving during S_TX_WAIT is dropped; opcode upper bits ignored.
        send_byte(8'h80);
        send_byte(8'h02);
        send_op(8'hC3, 8'hE0);
        check("op_upper_ignored", 32'(op), 32'h03);
        wait_tx_start();
        @(negedge clock);
        drop_q.push_back(cyc + 1);
        send_byte(8'hAA);
        check("tx_data_held", 32'(tx_data), 32'hE0);
        check("data_a_after_drop", 32'(data_a), 32'h80);
        end_tx();
        run_txn(8'h0C, 8'h0A, 8'h26, 8'h06);

        // Reset while waiting for the opcode byte.
        send_byte(8'h11);
        send_byte(8'h22);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_all_zero("mid_reset");
        run_txn(8'h07, 8'h02, 8'h24, 8'h02);

        // Long idle gap after the A byte.
        send_byte(8'h01);
        repeat (20) @(negedge clock);
        check("busy_idle", 32'(busy), 32'd0);
`ifdef ALU_SEQ_TIMEOUT_EN
        send_byte(8'h02);
        send_byte(8'h03);
        send_op(8'h20, 8'h05);
        check("data_a_after_timeout", 32'(data_a), 32'h02);
`else
        send_byte(8'h02);
        send_op(8'h20, 8'h03);
        check("data_a_no_timeout", 32'(data_a), 32'h01);
`endif
        wait_tx_start();
        @(negedge clock);

        // rx_done and tx_done together in S_TX_WAIT.
        drop_q.push_back(cyc + 1);
        rx_data = 8'h99;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clock);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("busy_after_both", 32'(busy), 32'd0);
`ifdef ALU_SEQ_TIMEOUT_EN
        check("data_a_not_latched", 32'(data_a), 32'h02);
`else
        check("data_a_not_latched", 32'(data_a), 32'h01);
`endif
        run_txn(8'h09, 8'h04, 8'h27, 8'hF2);

        repeat (5) @(negedge clock);
        check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
        check("drop_queue_empty", 32'(drop_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Operand/result sequencer between the UART byte receiver/transmitter and the registered ALU. It collects three consecutive received bytes (operand A, operand B, opcode) and holds them on the ALU inputs. After the ALU's one-cycle registered latency it captures the result and hands it to the UART transmitter with a start/done handshake. It lets the ALU be exercised from a host over serial instead of board switches.

## Interface
Parameters:
- N_BITS, 8, byte/operand/result width; matches ALU N_BITS and UART data width
- N_OPS, 6, opcode width; must be <= N_BITS
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in clocks (used only with ALU_SEQ_TIMEOUT_EN)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- rx_data  in  N_BITS  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle strobe from UART receiver
- tx_done  in  1  one-cycle strobe from UART transmitter, byte finished
- alu_result  in  N_BITS  registered ALU output
- data_a  out  N_BITS  operand A to ALU
- data_b  out  N_BITS  operand B to ALU
- op  out  N_OPS  opcode to ALU
- tx_data  out  N_BITS  byte to transmit, stable from tx_start until tx_done
- tx_start  out  1  one-cycle transmit request
- busy  out  1  high in S_EXEC, S_CAPTURE, S_TX_WAIT
- rx_drop  out  1  one-cycle pulse when a received byte is discarded

## Operation
- States: S_A, S_B, S_OP, S_EXEC, S_CAPTURE, S_TX_WAIT. Reset state S_A.
- S_A: on rx_done, data_a <= rx_data and go to S_B.
- S_B: on rx_done, data_b <= rx_data and go to S_OP.
- S_OP: on rx_done, op <= rx_data[N_OPS-1:0] and go to S_EXEC. Upper byte bits are ignored.
- S_EXEC: unconditional, one cycle. The ALU registers the result at the end of this cycle.
- S_CAPTURE: tx_data <= alu_result, tx_start <= 1, go to S_TX_WAIT.
- S_TX_WAIT: tx_start is 0. On tx_done, go to S_A.
- data_a, data_b and op hold their values until overwritten. They are not cleared between transactions.
- rx_done in S_EXEC, S_CAPTURE or S_TX_WAIT: byte discarded, rx_drop pulses the next cycle, state unaffected.
- rx_done and tx_done in the same cycle in S_TX_WAIT: go to S_A, the byte is discarded, rx_drop pulses.
- tx_done outside S_TX_WAIT: ignored.
- Arithmetic: none. All paths are pure register transfers at N_BITS width.

## Timing
- Reset (reset_n=0 at an edge): all outputs become 0, state S_A, timeout counter 0. This takes priority over every other event, including mid-transaction.
- Op byte rx_done sampled at edge k:
  - op is updated at edge k.
  - The ALU result is registered at edge k+1.
  - tx_data is valid and tx_start=1 after edge k+2.
  - tx_start returns to 0 after edge k+3.
- Minimum turnaround: the next A byte is accepted at the first edge after the tx_done edge.
- busy and rx_drop are registered outputs.

## Configuration
- Macro ALU_SEQ_TIMEOUT_EN.
- When defined:
  - A counter runs while in S_B or S_OP. It is cleared on every state change and on every rx_done.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_done, the state returns to S_A. The partial data_a/data_b values are left in the registers but are not sent.
  - Counter width is $clog2(TIMEOUT_CYCLES).
  - A rx_done in the same cycle as expiry wins: the byte is accepted and there is no timeout.
- When undefined: no counter, and S_B/S_OP wait indefinitely.

## Structure
- Shared package alu_seq_pkg: state enum encoding (3 bits), default widths, opcode constants (ADD 6'b100000, SUB 6'b100010, AND, OR, XOR, SRA, SRL, NOR). The bench model shares these constants.
- The timeout counter is a natural sub-module: seq_timeout_timer (clear, enable, expire pulse), instantiated only under ALU_SEQ_TIMEOUT_EN.
- The top-level test wrapper instantiates uart_rx, this block, ALU and uart_tx.

## Test plan
- Bytes 0x05, 0x03, 0x20 with real ALU -> op=0x20, tx_start pulse 3 edges after the op-byte rx_done, tx_data=0x08, busy high until tx_done.
- Bytes 0x03, 0x05, 0x22 (SUB) -> tx_data=0xFE. A second back-to-back transaction 0xF0, 0x0F, 0x25 (OR) -> tx_data=0xFF.
- rx_done 0xAA during S_TX_WAIT -> rx_drop pulse, tx_data unchanged. The next transaction starts cleanly at S_A.
- reset_n low for one edge while in S_OP after A=0x11, B=0x22 -> all outputs 0, state S_A. The following 3-byte sequence is processed normally.
- With ALU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: A byte, then 16 idle cycles -> return to S_A, no tx_start. The next three bytes form a complete transaction.
- rx_done and tx_done asserted in the same cycle -> state S_A, rx_drop=1, the byte is not latched into data_a.
